// File: rtl/wb_regfile.sv
// wb_regfile: NREG x DW register file with writeback port, registered
// two-operand read port and per-register pending-writeback scoreboard.
// Optional feature macro: WB_REGFILE_BYPASS_EN
// When it is defined, a same-cycle writeback is forwarded to the readers and
// counts toward clearing the read hazard. Without it, the reader waits one
// extra cycle and sees the written data from the register array.
module wb_regfile #(
    parameter int NREG    = 16,
    parameter int DW      = 32,
    parameter int MAXPEND = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            isWb,
    input  logic [3:0]      muxaddr,
    input  logic [DW-1:0]   muxdata,
    input  logic            rd_en,
    input  logic [3:0]      rs1,
    input  logic [3:0]      rs2,
    input  logic            iss_valid,
    input  logic [3:0]      iss_rd,
    output logic [DW-1:0]   op1,
    output logic [DW-1:0]   op2,
    output logic            op_valid,
    output logic            stall,
    output logic [NREG-1:0] pend_vec
);

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [1:0] MAXPEND_C = 2'(MAXPEND);

    logic [DW-1:0]   regs_r     [NREG];
    logic [1:0]      cnt_r      [NREG];
    logic [1:0]      cnt_next_s [NREG];
    logic [NREG-1:0] pend_r;
    logic [DW-1:0]   op1_r;
    logic [DW-1:0]   op2_r;
    logic            op_valid_r;

    logic            wb_hit1_s;
    logic            wb_hit2_s;
    logic            wb_hit_iss_s;
    logic            rd_hazard_s;
    logic            iss_full_s;
    logic            stall_s;
    logic            rd_go_s;
    logic            iss_go_s;
    logic [DW-1:0]   rd1_data_s;
    logic [DW-1:0]   rd2_data_s;

    // A source is busy when writebacks are still owed to it; with forwarding,
    // a same-cycle writeback settling the last one retires the hazard.
    function automatic logic src_busy(input logic [1:0] cnt, input logic wb_hit);
        src_busy = (cnt > 2'd1) || ((cnt == 2'd1) && !(wb_hit && BYPASS));
    endfunction

    // Hazard detection, stall generation and read data selection.
    always_comb begin
        wb_hit1_s    = isWb && (muxaddr == rs1);
        wb_hit2_s    = isWb && (muxaddr == rs2);
        wb_hit_iss_s = isWb && (muxaddr == iss_rd);
        if (rd_en) begin
            rd_hazard_s = src_busy(cnt_r[rs1], wb_hit1_s) ||
                          src_busy(cnt_r[rs2], wb_hit2_s);
        end else begin
            rd_hazard_s = 1'b0;
        end
        if (iss_valid) begin
            iss_full_s = (cnt_r[iss_rd] == MAXPEND_C) && !wb_hit_iss_s;
        end else begin
            iss_full_s = 1'b0;
        end
        stall_s  = rd_hazard_s || iss_full_s;
        rd_go_s  = rd_en && !stall_s;
        iss_go_s = iss_valid && !stall_s;
        if (BYPASS && wb_hit1_s) begin
            rd1_data_s = muxdata;
        end else begin
            rd1_data_s = regs_r[rs1];
        end
        if (BYPASS && wb_hit2_s) begin
            rd2_data_s = muxdata;
        end else begin
            rd2_data_s = regs_r[rs2];
        end
    end

    // Next value of each pending counter: issue adds, writeback retires,
    // both together cancel; saturate at MAXPEND and at zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (iss_go_s && (iss_rd == 4'(i)) && !(isWb && (muxaddr == 4'(i)))) begin
                if (cnt_r[i] != MAXPEND_C) begin
                    cnt_next_s[i] = cnt_r[i] + 2'd1;
                end else begin
                    cnt_next_s[i] = cnt_r[i];
                end
            end else if (isWb && (muxaddr == 4'(i)) && !(iss_go_s && (iss_rd == 4'(i)))) begin
                if (cnt_r[i] != 2'd0) begin
                    cnt_next_s[i] = cnt_r[i] - 2'd1;
                end else begin
                    cnt_next_s[i] = cnt_r[i];
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Register array write port and scoreboard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
                cnt_r[i]  <= 2'd0;
            end
            pend_r <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (isWb && (muxaddr == 4'(i))) begin
                    regs_r[i] <= muxdata;
                end
                cnt_r[i]  <= cnt_next_s[i];
                pend_r[i] <= (cnt_next_s[i] != 2'd0);
            end
        end
    end

    // Operand capture: load on an accepted read, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_r      <= '0;
            op2_r      <= '0;
            op_valid_r <= 1'b0;
        end else if (rd_go_s) begin
            op1_r      <= rd1_data_s;
            op2_r      <= rd2_data_s;
            op_valid_r <= 1'b1;
        end else begin
            op_valid_r <= 1'b0;
        end
    end

    assign op1      = op1_r;
    assign op2      = op2_r;
    assign op_valid = op_valid_r;
    assign stall    = stall_s;
    assign pend_vec = pend_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile. Inputs change 1 time unit after the
// rising edge; combinational stall is checked before the next edge and
// registered outputs 1 time unit after the edge that loads them.
module tb_wb_regfile;

    localparam int NREG = 16;
    localparam int DW   = 32;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            isWb;
    logic [3:0]      muxaddr;
    logic [DW-1:0]   muxdata;
    logic            rd_en;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic            iss_valid;
    logic [3:0]      iss_rd;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic            op_valid;
    logic            stall;
    logic [NREG-1:0] pend_vec;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile #(.NREG(NREG), .DW(DW), .MAXPEND(3)) dut (
        .clk(clk), .rst_n(rst_n), .isWb(isWb), .muxaddr(muxaddr),
        .muxdata(muxdata), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .op1(op1), .op2(op2),
        .op_valid(op_valid), .stall(stall), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; isWb = 1'b0; muxaddr = 4'd0; muxdata = 32'h0;
        rd_en = 1'b0; rs1 = 4'd0; rs2 = 4'd0; iss_valid = 1'b0; iss_rd = 4'd0;
        #12;
        chk("rst_op1", op1, 32'h0);
        chk("rst_op2", op2, 32'h0);
        chk("rst_opv", {31'd0, op_valid}, 32'h0);
        chk("rst_pend", {16'd0, pend_vec}, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // cold read of r3/r15
        rd_en = 1'b1; rs1 = 4'd3; rs2 = 4'd15;
        #1 chk("cold_stall", {31'd0, stall}, 32'h0);
        tick();
        chk("cold_op1", op1, 32'h0);
        chk("cold_op2", op2, 32'h0);
        chk("cold_opv", {31'd0, op_valid}, 32'h1);
        rd_en = 1'b0;

        // write r5, read it on both ports
        isWb = 1'b1; muxaddr = 4'd5; muxdata = 32'hA5A5A5A5;
        tick();
        isWb = 1'b0; rd_en = 1'b1; rs1 = 4'd5; rs2 = 4'd5;
        tick();
        chk("r5_op1", op1, 32'hA5A5A5A5);
        chk("r5_op2_same", op2, 32'hA5A5A5A5);
        chk("r5_opv", {31'd0, op_valid}, 32'h1);
        rd_en = 1'b0;
        tick();
        chk("idle_opv", {31'd0, op_valid}, 32'h0);
        chk("idle_hold", op1, 32'hA5A5A5A5);

        // write r3, read r3/r5
        isWb = 1'b1; muxaddr = 4'd3; muxdata = 32'h12345678;
        tick();
        isWb = 1'b0; rd_en = 1'b1; rs1 = 4'd3; rs2 = 4'd5;
        tick();
        chk("r3_op1", op1, 32'h12345678);
        chk("r3_op2", op2, 32'hA5A5A5A5);
        rd_en = 1'b0;

        // call to r15, hazard on read, resolve by writeback
        iss_valid = 1'b1; iss_rd = 4'd15;
        #1 chk("iss15_stall", {31'd0, stall}, 32'h0);
        tick();
        iss_valid = 1'b0;
        chk("iss15_pend", {16'd0, pend_vec}, 32'h00008000);
        rd_en = 1'b1; rs1 = 4'd15; rs2 = 4'd0;
        #1 chk("raw15_stall", {31'd0, stall}, 32'h1);
        tick();
        chk("raw15_opv", {31'd0, op_valid}, 32'h0);
        chk("raw15_hold", op1, 32'h12345678);
        isWb = 1'b1; muxaddr = 4'd15; muxdata = 32'h00000014;
        #1 chk("wb15_stall", {31'd0, stall}, {31'd0, !BYP});
        tick();
        isWb = 1'b0;
        chk("wb15_opv", {31'd0, op_valid}, {31'd0, BYP});
        chk("wb15_pend", {16'd0, pend_vec}, 32'h0);
        #1 chk("after15_stall", {31'd0, stall}, 32'h0);
        tick();
        chk("after15_op1", op1, 32'h00000014);
        chk("after15_opv", {31'd0, op_valid}, 32'h1);
        rd_en = 1'b0;

        // same-cycle writeback/read of pending r5
        iss_valid = 1'b1; iss_rd = 4'd5;
        tick();
        iss_valid = 1'b0;
        isWb = 1'b1; muxaddr = 4'd5; muxdata = 32'hDEADBEEF;
        rd_en = 1'b1; rs1 = 4'd5; rs2 = 4'd15;
        #1 chk("wb5_stall", {31'd0, stall}, {31'd0, !BYP});
        tick();
        isWb = 1'b0;
        chk("wb5_opv", {31'd0, op_valid}, {31'd0, BYP});
        #1 chk("rd5_stall", {31'd0, stall}, 32'h0);
        tick();
        chk("rd5_op1", op1, 32'hDEADBEEF);
        chk("rd5_op2", op2, 32'h00000014);
        chk("rd5_opv", {31'd0, op_valid}, 32'h1);
        rd_en = 1'b0;

        // writeback with zero counter stays at zero
        isWb = 1'b1; muxaddr = 4'd9; muxdata = 32'h99;
        tick();
        isWb = 1'b0;
        chk("under9_pend", {16'd0, pend_vec}, 32'h0);
        iss_valid = 1'b1; iss_rd = 4'd9;
        tick();
        iss_valid = 1'b0;
        chk("iss9_pend", {16'd0, pend_vec}, 32'h00000200);
        isWb = 1'b1; muxaddr = 4'd9;
        tick();
        isWb = 1'b0;
        chk("ret9_pend", {16'd0, pend_vec}, 32'h0);

        // fill r7 to MAXPEND
        iss_valid = 1'b1; iss_rd = 4'd7;
        for (int k = 0; k < 3; k++) begin
            #1 chk("fill7_stall", {31'd0, stall}, 32'h0);
            tick();
        end
        iss_valid = 1'b0;
        chk("fill7_pend", {16'd0, pend_vec}, 32'h00000080);
        // stalled issue must not touch r11
        rd_en = 1'b1; rs1 = 4'd0; rs2 = 4'd7; iss_valid = 1'b1; iss_rd = 4'd11;
        #1 chk("rs2_7_stall", {31'd0, stall}, 32'h1);
        tick();
        rd_en = 1'b0; iss_valid = 1'b0;
        chk("stalled_iss11", {16'd0, pend_vec}, 32'h00000080);
        iss_valid = 1'b1; iss_rd = 4'd7;
        #1 chk("full7_stall", {31'd0, stall}, 32'h1);
        tick();
        isWb = 1'b1; muxaddr = 4'd7; muxdata = 32'h77;
        #1 chk("issret7_stall", {31'd0, stall}, 32'h0);
        tick();
        isWb = 1'b0;
        #1 chk("still7_full", {31'd0, stall}, 32'h1);
        iss_valid = 1'b0;
        tick();

        // asynchronous reset mid-operation
        rd_en = 1'b1; rs1 = 4'd3; rs2 = 4'd5;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_opv", {31'd0, op_valid}, 32'h1);
        chk("pre_rst_pend", {16'd0, pend_vec}, 32'h00000080);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_opv", {31'd0, op_valid}, 32'h0);
        chk("arst_pend", {16'd0, pend_vec}, 32'h0);
        chk("arst_op1", op1, 32'h0);
        chk("arst_op2", op2, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        rd_en = 1'b1; rs1 = 4'd5; rs2 = 4'd3;
        #1 chk("post_rst_stall", {31'd0, stall}, 32'h0);
        tick();
        rd_en = 1'b0;
        chk("post_rst_op1", op1, 32'h0);
        chk("post_rst_op2", op2, 32'h0);
        chk("post_rst_opv", {31'd0, op_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
